// File: rtl/stack_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stack_controller_if                                           |
// | Brief    : Controller <-> datapath strobe bundle (CTRL_STEP_EN adds step)|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface stack_controller_if;
    logic [2:0] opcode;
    logic       a_zero;
`ifdef CTRL_STEP_EN
    logic       step;
`endif
    logic       LorD;
    logic       read;
    logic       write;
    logic       StackSrc;
    logic       tos;
    logic       push;
    logic       pop;
    logic       RegDst;
    logic       LA;
    logic       LB;
    logic       LR;
    logic       PCL;
    logic       Ain;
    logic       Bin;
    logic [1:0] ALUop;
    logic       next;
    logic       jump;
    logic [3:0] state;
    logic       instr_done;

    modport master (
`ifdef CTRL_STEP_EN
        input  step,
`endif
        input  opcode, a_zero,
        output LorD, read, write, StackSrc, tos, push, pop, RegDst,
               LA, LB, LR, PCL, Ain, Bin, ALUop, next, jump, state, instr_done
    );

    modport slave (
`ifdef CTRL_STEP_EN
        output step,
`endif
        output opcode, a_zero,
        input  LorD, read, write, StackSrc, tos, push, pop, RegDst,
               LA, LB, LR, PCL, Ain, Bin, ALUop, next, jump, state, instr_done
    );
endinterface
`default_nettype wire

// File: rtl/stack_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stack_controller                                              |
// | Brief    : Multicycle Moore sequencer for the 8-bit stack-machine        |
// |            datapath. Optional single-step mode via CTRL_STEP_EN.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module stack_controller #(
    parameter logic [1:0] ALU_ADD = 2'b00,
    parameter logic [1:0] ALU_SUB = 2'b01,
    parameter logic [1:0] ALU_AND = 2'b10,
    parameter logic [1:0] ALU_NOT = 2'b11
) (
    input wire                 clk,
    input wire                 rst,
    stack_controller_if.master ctrl
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_POPA   = 4'd3,
        S_POPB   = 4'd4,
        S_EXEC   = 4'd5,
        S_PUSHR  = 4'd6,
        S_PUSHM  = 4'd7,
        S_MEMWR  = 4'd8,
        S_JMPS   = 4'd9,
        S_JZS    = 4'd10
`ifdef CTRL_STEP_EN
        ,
        S_WAIT   = 4'd11
`endif
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_NOT  = 3'b011;
    localparam logic [2:0] c_OP_PUSH = 3'b100;
    localparam logic [2:0] c_OP_POP  = 3'b101;
    localparam logic [2:0] c_OP_JMP  = 3'b110;
    localparam logic [2:0] c_OP_JZ   = 3'b111;

    // Where INIT and every final state hand control back to.
`ifdef CTRL_STEP_EN
    localparam state_t c_RESUME = S_WAIT;
`else
    localparam state_t c_RESUME = S_FETCH;
`endif

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] w_aluOp;

    logic       r_LorD;
    logic       r_read;
    logic       r_write;
    logic       r_StackSrc;
    logic       r_tos;
    logic       r_push;
    logic       r_pop;
    logic       r_LA;
    logic       r_LB;
    logic       r_LR;
    logic       r_PCL;
    logic       r_Ain;
    logic       r_Bin;
    logic [1:0] r_ALUop;
    logic       r_next;
    logic       r_jump;
    logic       r_jzArm;
    logic       r_instrDone;
    logic       w_jzTake;

    always_comb begin
        case (ctrl.opcode)
            c_OP_SUB: w_aluOp = ALU_SUB;
            c_OP_AND: w_aluOp = ALU_AND;
            c_OP_NOT: w_aluOp = ALU_NOT;
            default:  w_aluOp = ALU_ADD;
        endcase
    end

    always_comb begin
        w_nextState = S_INIT;
        case (r_state)
            S_INIT:   w_nextState = c_RESUME;
            S_FETCH:  w_nextState = S_DECODE;
            S_DECODE: begin
                case (ctrl.opcode)
                    c_OP_PUSH: w_nextState = S_PUSHM;
                    c_OP_JMP:  w_nextState = S_JMPS;
                    default:   w_nextState = S_POPA;
                endcase
            end
            S_POPA: begin
                case (ctrl.opcode)
                    c_OP_ADD, c_OP_SUB, c_OP_AND: w_nextState = S_POPB;
                    c_OP_NOT:                     w_nextState = S_EXEC;
                    c_OP_POP:                     w_nextState = S_MEMWR;
                    c_OP_JZ:                      w_nextState = S_JZS;
                    default:                      w_nextState = S_INIT;
                endcase
            end
            S_POPB:   w_nextState = S_EXEC;
            S_EXEC:   w_nextState = S_PUSHR;
            S_PUSHR, S_PUSHM, S_MEMWR, S_JMPS, S_JZS:
                      w_nextState = c_RESUME;
`ifdef CTRL_STEP_EN
            S_WAIT:   w_nextState = ctrl.step ? S_FETCH : S_WAIT;
`endif
            default:  w_nextState = S_INIT;
        endcase
    end

    // Outputs are decoded from the state being entered so they are registered
    // alongside r_state; reset and illegal codes both land in all-zero INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_LorD      <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_StackSrc  <= 1'b0;
            r_tos       <= 1'b0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_LA        <= 1'b0;
            r_LB        <= 1'b0;
            r_LR        <= 1'b0;
            r_PCL       <= 1'b0;
            r_Ain       <= 1'b0;
            r_Bin       <= 1'b0;
            r_ALUop     <= ALU_ADD;
            r_next      <= 1'b0;
            r_jump      <= 1'b0;
            r_jzArm     <= 1'b0;
            r_instrDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_LorD      <= (w_nextState == S_FETCH);
            r_read      <= (w_nextState == S_FETCH) || (w_nextState == S_PUSHM);
            r_write     <= (w_nextState == S_MEMWR);
            r_StackSrc  <= (w_nextState == S_PUSHR);
            r_tos       <= (w_nextState == S_POPA) || (w_nextState == S_POPB);
            r_push      <= (w_nextState == S_PUSHR) || (w_nextState == S_PUSHM);
            r_pop       <= (w_nextState == S_POPA) || (w_nextState == S_POPB);
            r_LA        <= (w_nextState == S_POPA);
            r_LB        <= (w_nextState == S_POPB);
            r_LR        <= (w_nextState == S_FETCH);
            r_PCL       <= (w_nextState == S_FETCH) || (w_nextState == S_JMPS);
            r_Ain       <= (w_nextState == S_FETCH);
            r_Bin       <= (w_nextState == S_EXEC);
            r_ALUop     <= (w_nextState == S_EXEC) ? w_aluOp : ALU_ADD;
            r_next      <= (w_nextState == S_FETCH);
            r_jump      <= (w_nextState == S_JMPS);
            r_jzArm     <= (w_nextState == S_JZS);
            r_instrDone <= (w_nextState == S_PUSHR) || (w_nextState == S_PUSHM) ||
                           (w_nextState == S_MEMWR) || (w_nextState == S_JMPS)  ||
                           (w_nextState == S_JZS);
        end
    end

    // regA is loaded on the same edge that enters JZS, so the zero flag is
    // only valid during JZS itself and has to qualify the branch there.
    assign w_jzTake = r_jzArm & ctrl.a_zero;

    assign ctrl.LorD       = r_LorD;
    assign ctrl.read       = r_read;
    assign ctrl.write      = r_write;
    assign ctrl.StackSrc   = r_StackSrc;
    assign ctrl.tos        = r_tos;
    assign ctrl.push       = r_push;
    assign ctrl.pop        = r_pop;
    assign ctrl.RegDst     = 1'b0;
    assign ctrl.LA         = r_LA;
    assign ctrl.LB         = r_LB;
    assign ctrl.LR         = r_LR;
    assign ctrl.PCL        = r_PCL | w_jzTake;
    assign ctrl.Ain        = r_Ain;
    assign ctrl.Bin        = r_Bin;
    assign ctrl.ALUop      = r_ALUop;
    assign ctrl.next       = r_next;
    assign ctrl.jump       = r_jump | w_jzTake;
    assign ctrl.state      = r_state;
    assign ctrl.instr_done = r_instrDone;

endmodule
`default_nettype wire

// File: tb/tb_stack_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_stack_controller                                           |
// | Brief    : Directed bench: controller driving a behavioural datapath.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_stack_controller;

    logic clk;
    logic rst;
    logic dpLoad;
    int   nChecks;
    int   nPass;

    stack_controller_if bus ();

    stack_controller dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapath: 32-byte memory, 16-deep stack, A/B/IR/PC/ALU regs.
    logic [7:0]  mem    [32];
    logic [7:0]  memImg [32];
    logic [7:0]  stk    [16];
    logic [7:0]  stkImg [16];
    logic [3:0]  sp, spImg;
    logic [7:0]  PC, IR, regA, regB, aluReg;
    logic [4:0]  addr;
    logic [7:0]  rdData, topVal, aluA, aluB, aluOut;
    logic [18:0] outs;

    assign addr   = bus.LorD ? PC[4:0] : IR[4:0];
    assign rdData = mem[addr];
    assign topVal = stk[sp - 4'd1];
    assign aluA   = bus.Ain ? PC : regA;
    assign aluB   = bus.Bin ? regB : 8'd1;
    assign bus.opcode = IR[7:5];
    assign bus.a_zero = (regA == 8'h00);
    assign outs = {bus.LorD, bus.read, bus.write, bus.StackSrc,
                   bus.tos, bus.push, bus.pop, bus.RegDst,
                   bus.LA, bus.LB, bus.LR, bus.PCL,
                   bus.Ain, bus.Bin, bus.ALUop,
                   bus.next, bus.jump, bus.instr_done};

    always_comb begin
        aluOut = 8'h00;
        case (bus.ALUop)
            2'b00: aluOut = aluA + aluB;
            2'b01: aluOut = aluA - aluB;
            2'b10: aluOut = aluA & aluB;
            2'b11: aluOut = ~aluA;
        endcase
    end

    always @(posedge clk) begin
        if (dpLoad) begin
            mem    <= memImg;
            stk    <= stkImg;
            sp     <= spImg;
            PC     <= 8'h00;
            IR     <= 8'h00;
            regA   <= 8'h00;
            regB   <= 8'h00;
            aluReg <= 8'h00;
        end else begin
            aluReg <= aluOut;
            if (bus.LR)  IR   <= rdData;
            if (bus.LA)  regA <= topVal;
            if (bus.LB)  regB <= topVal;
            if (bus.PCL) PC   <= bus.next ? aluOut : (bus.jump ? {3'b000, IR[4:0]} : PC);
            if (bus.pop) sp   <= sp - 4'd1;
            if (bus.push) begin
                stk[sp] <= bus.StackSrc ? aluReg : rdData;
                sp      <= sp + 4'd1;
            end
            if (bus.write) mem[addr] <= regA;
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            nPass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectState(input string tag, input logic [3:0] exp);
        tick();
        checkValue(tag, 32'(bus.state), 32'(exp));
    endtask

    task automatic clearImages();
        for (int i = 0; i < 32; i++) memImg[i] = 8'h00;
        for (int i = 0; i < 16; i++) stkImg[i] = 8'h00;
        spImg = 4'd0;
    endtask

    task automatic startProgram();
        rst    = 1'b1;
        dpLoad = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        dpLoad = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nChecks = 0;
        nPass   = 0;
        rst     = 1'b1;
        dpLoad  = 1'b1;
`ifdef CTRL_STEP_EN
        bus.step = 1'b0;
`endif

        // PUSH 3 from address 0
        clearImages();
        memImg[0] = 8'b100_00011;
        memImg[3] = 8'h3C;
        startProgram();
        checkValue("reset_state", 32'(bus.state), 32'd0);
        checkValue("reset_outs", 32'(outs), 32'd0);

`ifdef CTRL_STEP_EN
        expectState("step_wait0", 4'd11);
        expectState("step_wait1", 4'd11);
        expectState("step_wait2", 4'd11);
        checkValue("step_wait_outs", 32'(outs), 32'd0);
        bus.step = 1'b1;
        expectState("step_fetch", 4'd1);
        bus.step = 1'b0;
        expectState("step_decode", 4'd2);
        expectState("step_pushm", 4'd7);
        expectState("step_back_wait", 4'd11);
        expectState("step_hold_wait", 4'd11);
        checkValue("step_stk0", 32'(stk[0]), 32'h3C);
        checkValue("step_sp", 32'(sp), 32'd1);
        checkValue("step_pc", 32'(PC), 32'd1);
`else
        expectState("push_fetch", 4'd1);
        checkValue("fetch_outs", 32'(outs), 32'(19'b1100_0000_0011_1000_100));
        expectState("push_decode", 4'd2);
        checkValue("decode_outs", 32'(outs), 32'd0);
        expectState("push_pushm", 4'd7);
        checkValue("pushm_outs", 32'(outs), 32'(19'b0100_0100_0000_0000_001));
        checkValue("push_pc", 32'(PC), 32'd1);
        expectState("push_refetch", 4'd1);
        checkValue("push_stk0", 32'(stk[0]), 32'h3C);
        checkValue("push_sp", 32'(sp), 32'd1);

        // SUB with stack [top 9, 4]
        clearImages();
        memImg[0] = 8'b001_00000;
        stkImg[0] = 8'd4;
        stkImg[1] = 8'd9;
        spImg     = 4'd2;
        startProgram();
        expectState("sub_fetch", 4'd1);
        expectState("sub_decode", 4'd2);
        expectState("sub_popa", 4'd3);
        checkValue("popa_outs", 32'(outs), 32'(19'b0000_1010_1000_0000_000));
        expectState("sub_popb", 4'd4);
        expectState("sub_exec", 4'd5);
        checkValue("exec_sub_outs", 32'(outs), 32'(19'b0000_0000_0000_0101_000));
        expectState("sub_pushr", 4'd6);
        checkValue("pushr_outs", 32'(outs), 32'(19'b0001_0100_0000_0000_001));
        expectState("sub_refetch", 4'd1);
        checkValue("sub_result", 32'(stk[0]), 32'd5);
        checkValue("sub_sp", 32'(sp), 32'd1);

        // JZ 20 taken (top = 0)
        clearImages();
        memImg[0] = 8'b111_10100;
        spImg     = 4'd1;
        startProgram();
        expectState("jz_fetch", 4'd1);
        expectState("jz_decode", 4'd2);
        expectState("jz_popa", 4'd3);
        expectState("jz_jzs", 4'd10);
        checkValue("jzs_taken_outs", 32'(outs), 32'(19'b0000_0000_0001_0000_011));
        expectState("jz_refetch", 4'd1);
        checkValue("jz_taken_pc", 32'(PC), 32'd20);

        // JZ 20 not taken (top = 7)
        stkImg[0] = 8'd7;
        startProgram();
        expectState("jzn_fetch", 4'd1);
        expectState("jzn_decode", 4'd2);
        expectState("jzn_popa", 4'd3);
        expectState("jzn_jzs", 4'd10);
        checkValue("jzs_nottaken_outs", 32'(outs), 32'(19'b0000_0000_0000_0000_001));
        expectState("jzn_refetch", 4'd1);
        checkValue("jz_nottaken_pc", 32'(PC), 32'd1);

        // POP 17 of A5, then NOT on 0F
        clearImages();
        memImg[0] = 8'b101_10001;
        memImg[1] = 8'b011_00000;
        stkImg[0] = 8'h0F;
        stkImg[1] = 8'hA5;
        spImg     = 4'd2;
        startProgram();
        expectState("pop_fetch", 4'd1);
        expectState("pop_decode", 4'd2);
        expectState("pop_popa", 4'd3);
        expectState("pop_memwr", 4'd8);
        checkValue("memwr_outs", 32'(outs), 32'(19'b0010_0000_0000_0000_001));
        expectState("pop_refetch", 4'd1);
        checkValue("pop_mem17", 32'(mem[17]), 32'hA5);
        expectState("not_decode", 4'd2);
        expectState("not_popa", 4'd3);
        expectState("not_exec", 4'd5);
        checkValue("exec_not_outs", 32'(outs), 32'(19'b0000_0000_0000_0111_000));
        expectState("not_pushr", 4'd6);
        expectState("not_refetch", 4'd1);
        checkValue("not_result", 32'(stk[0]), 32'hF0);
        checkValue("not_sp", 32'(sp), 32'd1);

        // Reset during POPB of an ADD, then PUSH 3 from address 1
        clearImages();
        memImg[0] = 8'b000_00000;
        memImg[1] = 8'b100_00011;
        memImg[3] = 8'h55;
        stkImg[0] = 8'd2;
        stkImg[1] = 8'd3;
        spImg     = 4'd2;
        startProgram();
        expectState("abort_fetch", 4'd1);
        expectState("abort_decode", 4'd2);
        expectState("abort_popa", 4'd3);
        expectState("abort_popb", 4'd4);
        rst = 1'b1;
        expectState("abort_init", 4'd0);
        checkValue("abort_outs", 32'(outs), 32'd0);
        tick();
        checkValue("abort_no_push", 32'(sp), 32'd0);
        rst = 1'b0;
        expectState("restart_fetch", 4'd1);
        expectState("restart_decode", 4'd2);
        expectState("restart_pushm", 4'd7);
        expectState("restart_refetch", 4'd1);
        checkValue("restart_stk0", 32'(stk[0]), 32'h55);
        checkValue("restart_sp", 32'(sp), 32'd1);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Multicycle Moore FSM that sequences the 8-bit stack-machine datapath: PC, IR, memory, stack, A/B registers, ALU and the PC-decide mux.
- Consumes IR opcode[2:0] plus a regA zero flag; drives every datapath control strobe.
- Sits beside the datapath in the CPU top level. One instruction completes in 3–6 cycles.

Parameters:
- ALU_ADD, 2'b00, ALUop code for add
- ALU_SUB, 2'b01, ALUop code for subtract (Ain − Bin)
- ALU_AND, 2'b10, ALUop code for bitwise and
- ALU_NOT, 2'b11, ALUop code for bitwise not of Ain

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  3  IR[7:5]
- a_zero  in  1  1 when regA == 8'h00 (zero-detect at top level)
- LorD  out  1  memory address select: 1 = PC, 0 = IR[4:0]
- read, write  out  1 each  memory read/write strobes
- StackSrc  out  1  stack push data: 0 = memory readData, 1 = ALU register
- tos, push, pop  out  1 each  stack top-read, push and pop
- RegDst  out  1  reserved, constant 0
- LA, LB, LR, PCL  out  1 each  load enables for A, B, IR and PC
- Ain  out  1  ALU A input: 0 = regA, 1 = PC (sign-extended)
- Bin  out  1  ALU B input: 0 = constant 1, 1 = regB
- ALUop  out  2  ALU operation select
- next, jump  out  1 each  decide mux: next = 1 takes ALU output; jump = 1 (with next = 0) takes IR[4:0]
- state  out  4  current state code (debug)
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH m, 101 POP m, 110 JMP m, 111 JZ m (m = IR[4:0]).
- Memory read is combinational. Stack top is valid combinationally when tos = 1. The datapath ALU register captures every cycle.
- States and their asserted outputs. Any output not listed is 0.
  - INIT (0): all outputs 0 → FETCH.
  - FETCH (1): LorD, read, LR, Ain, ALUop = ADD, Bin = 0, next, PCL. IR ← mem[PC]; PC ← PC + 1. → DECODE.
  - DECODE (2): no strobes. Next state by opcode: ADD/SUB/AND/NOT/POP/JZ → POPA; PUSH → PUSHM; JMP → JMPS.
  - POPA (3): tos, LA, pop. Next: ADD/SUB/AND → POPB; NOT → EXEC; POP → MEMWR; JZ → JZS.
  - POPB (4): tos, LB, pop → EXEC.
  - EXEC (5): Ain = 0, Bin = 1, ALUop from opcode (ADD/SUB/AND/NOT) → PUSHR.
  - PUSHR (6): StackSrc = 1, push, instr_done → FETCH.
  - PUSHM (7): LorD = 0, read, StackSrc = 0, push, instr_done → FETCH.
  - MEMWR (8): LorD = 0, write, instr_done → FETCH. mem[m] ← regA.
  - JMPS (9): jump, PCL, instr_done → FETCH.
  - JZS (10): if a_zero, jump and PCL; instr_done always → FETCH.
- Operand order: SUB result = first-popped (old top) − second-popped.
- Latencies from FETCH to FETCH: ADD/SUB/AND 6, NOT 5, POP/JZ 4, PUSH/JMP 3.
- Reset:
  - rst sampled high → state = INIT on the next edge; all outputs 0 in INIT.
  - rst mid-instruction aborts it; no further strobes are issued until FETCH.
- Illegal state codes 11–15 → INIT with all outputs 0.
- Push/pop are never asserted in the same cycle. read and write are never both 1.
- Stack overflow/underflow is not detected. The program must not pop an empty stack.

Optional Feature:
- CTRL_STEP_EN defined:
  - Adds input step (1 bit) and state WAIT (11).
  - INIT and every instr_done state go to WAIT instead of FETCH. WAIT (all outputs 0) moves to FETCH when step = 1, otherwise holds.
  - Single-step debug.
- CTRL_STEP_EN undefined: no step port, no WAIT state; behaviour exactly as above.

Test Plan:
- Reset then release with mem[0] = 100_00011 (PUSH 3) → state sequence INIT, FETCH, DECODE, PUSHM; push = 1 and StackSrc = 0 in PUSHM; PC = 1; instr_done pulse at cycle 3.
- Stack [top 9, 4], opcode SUB → POPA, POPB, EXEC with ALUop = 01, Ain = 0, Bin = 1; PUSHR pushes 8'd5; 6 cycles FETCH to FETCH.
- JZ 5'd20 with top = 0 → JZS asserts jump = 1, PCL = 1, and the next FETCH is at address 20. Repeat with top = 7 → PCL = 0 in JZS, next fetch at PC + 1.
- POP 5'd17 with top = 8'hA5 → MEMWR asserts LorD = 0 and write = 1; mem[17] = A5 afterwards. NOT on top = 8'h0F → pushes F0 in 5 cycles.
- rst asserted in POPB of an ADD → next cycle state = INIT with all outputs 0; no push occurs; fetch restarts.
- With CTRL_STEP_EN and step held 0 → FSM parks in WAIT; one step pulse → exactly one instruction executes, then back to WAIT.
